// File: rtl/led_frame_scanner_pkg.sv
// Shared LED matrix geometry, scanner states and the xy-to-index mapping
// used by both the frame printer and the frame scanner.
package led_frame_scanner_pkg;

  localparam int COLS  = 12;
  localparam int ROWS  = 8;
  localparam int NLEDS = COLS * ROWS;
  localparam int XW    = 4;
  localparam int YW    = 3;
  localparam int IW    = 7;
  localparam int CW    = 7;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } scan_state_e;

  function automatic logic [IW-1:0] led_index(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    return IW'(x) + IW'(COLS) * IW'(y);
  endfunction

endpackage

// File: rtl/led_frame_scanner_xy.sv
// Linear LED index with matching column/row counters; columns wrap
// into the next row so no divide is needed to recover (x,y).
module led_xy_counter #(
  parameter int COLS = 12,
  parameter int ROWS = 8,
  parameter int XW   = 4,
  parameter int YW   = 3,
  parameter int IW   = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [IW-1:0] idx,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [IW-1:0] idx_q, idx_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    idx_d = idx_q;
    x_d   = x_q;
    y_d   = y_q;
    if (clr) begin
      idx_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else if (adv) begin
      idx_d = idx_q + IW'(1);
      if (x_q == XW'(COLS - 1)) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      idx_q <= idx_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign idx  = idx_q;
  assign x    = x_q;
  assign y    = y_q;
  assign last = (idx_q == IW'(COLS * ROWS - 1));

endmodule

// File: rtl/led_frame_scanner.sv
// Walks a snapshot of the LED frame in index order and hands out the
// (x,y) of each lit LED over a valid/ready port, one run per start.
module led_frame_scanner
  import led_frame_scanner_pkg::*;
#(
  parameter int COLS = led_frame_scanner_pkg::COLS,
  parameter int ROWS = led_frame_scanner_pkg::ROWS,
  parameter int XW   = led_frame_scanner_pkg::XW,
  parameter int YW   = led_frame_scanner_pkg::YW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [COLS*ROWS-1:0] frame,
  output logic [XW-1:0]        out_x,
  output logic [YW-1:0]        out_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        lit_count
);

  scan_state_e state_q, state_d;

  logic [COLS*ROWS-1:0] snap_q, snap_d;
  logic [XW-1:0]        ox_q, ox_d;
  logic [YW-1:0]        oy_q, oy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        lit_q, lit_d;

  logic          clr, adv, last;
  logic [IW-1:0] idx;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;

  led_xy_counter #(
    .COLS(COLS),
    .ROWS(ROWS),
    .XW  (XW),
    .YW  (YW),
    .IW  (IW)
  ) u_xy (
    .clk (CLK),
    .rst (RST),
    .clr (clr),
    .adv (adv),
    .idx (idx),
    .x   (cx),
    .y   (cy),
    .last(last)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    cnt_d   = cnt_q;
    lit_d   = lit_q;
    clr     = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = frame;
          cnt_d   = '0;
          clr     = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (snap_q[idx]) begin
          ox_d    = cx;
          oy_d    = cy;
          state_d = EMIT;
        end else if (last) begin
          lit_d   = cnt_q;
          state_d = DONE;
        end else begin
          adv = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            // publish alongside the done pulse
            lit_d   = cnt_q + CW'(1);
            state_d = DONE;
          end else begin
            adv     = 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      snap_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      cnt_q   <= '0;
      lit_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      cnt_q   <= cnt_d;
      lit_q   <= lit_d;
    end
  end

  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == SCAN) || (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign lit_count = lit_q;

endmodule

// File: tb/tb_led_frame_scanner.sv
// Directed bench for led_frame_scanner: empty, sparse, full and
// mid-scan disturbance frames plus asynchronous reset in EMIT.
module tb_led_frame_scanner;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [95:0] frame;
  logic        out_ready;
  logic [3:0]  out_x;
  logic [2:0]  out_y;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [6:0]  lit_count;

  int vec  = 0;
  int errs = 0;
  int xs[$];
  int ys[$];

  led_frame_scanner dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .frame    (frame),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .lit_count(lit_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge where done is seen; cyc counts negedges
  // after the start edge (0 = first SCAN cycle).
  task automatic do_scan(input logic [95:0] f, input bit toggle,
                         input bit glitch, output int cyc);
    int         stall_err;
    bit         pv, phs, hs;
    logic [3:0] px;
    logic [2:0] py;
    stall_err = 0;
    pv = 1'b0;
    phs = 1'b0;
    px = '0;
    py = '0;
    xs.delete();
    ys.delete();
    @(negedge CLK);
    frame = f;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 0;
    while (cyc < 2000 && done !== 1'b1) begin
      hs = (out_valid === 1'b1) && (out_ready === 1'b1);
      if (pv && !phs && (out_valid !== 1'b1 || out_x !== px || out_y !== py))
        stall_err++;
      if (hs) begin
        xs.push_back(int'(out_x));
        ys.push_back(int'(out_y));
      end
      pv = (out_valid === 1'b1);
      phs = hs;
      px = out_x;
      py = out_y;
      @(negedge CLK);
      cyc++;
      if (toggle) out_ready = ~out_ready;
      if (glitch && cyc == 10) begin
        frame = '0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("scan_reaches_done", done, 1);
    chk("stall_hold", stall_err, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    int          cyc;
    int          w;
    int          bad;
    logic [95:0] f;

    RST = 1'b1;
    start = 1'b0;
    frame = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", out_x, 0);
    chk("rst_y", out_y, 0);
    chk("rst_lit", lit_count, 0);
    @(negedge CLK);
    RST = 1'b0;

    // empty frame: 96 SCAN cycles, done next
    do_scan('0, 1'b0, 1'b0, cyc);
    chk("empty_latency", cyc, 96);
    chk("empty_xfers", xs.size(), 0);
    chk("empty_lit", lit_count, 0);
    chk("empty_busy_in_done", busy, 0);

    // single LED at index 39 -> (3,3)
    f = 96'd1 << 39;
    do_scan(f, 1'b0, 1'b0, cyc);
    chk("b39_latency", cyc, 97);
    chk("b39_xfers", xs.size(), 1);
    if (xs.size() == 1) begin
      chk("b39_x", xs[0], 3);
      chk("b39_y", ys[0], 3);
    end
    chk("b39_lit", lit_count, 1);

    // corners and row wrap
    f = (96'd1 << 0) | (96'd1 << 11) | (96'd1 << 12) | (96'd1 << 95);
    do_scan(f, 1'b0, 1'b0, cyc);
    chk("four_latency", cyc, 100);
    chk("four_xfers", xs.size(), 4);
    if (xs.size() == 4) begin
      chk("four_x0", xs[0], 0);
      chk("four_y0", ys[0], 0);
      chk("four_x1", xs[1], 11);
      chk("four_y1", ys[1], 0);
      chk("four_x2", xs[2], 0);
      chk("four_y2", ys[2], 1);
      chk("four_x3", xs[3], 11);
      chk("four_y3", ys[3], 7);
    end
    chk("four_lit", lit_count, 4);

    // full frame with back-pressure every other cycle
    f = '1;
    do_scan(f, 1'b1, 1'b0, cyc);
    chk("full_xfers", xs.size(), 96);
    bad = 0;
    if (xs.size() == 96) begin
      for (int i = 0; i < 96; i++)
        if (xs[i] != i % 12 || ys[i] != i / 12) bad++;
    end else begin
      bad = -1;
    end
    chk("full_row_major", bad, 0);
    chk("full_lit", lit_count, 96);
    repeat (5) @(negedge CLK);
    chk("full_lit_held", lit_count, 96);
    chk("full_idle_busy", busy, 0);

    // frame cleared and start re-pulsed mid-scan: both ignored
    f = 96'd1 << 50;
    do_scan(f, 1'b0, 1'b1, cyc);
    chk("b50_latency", cyc, 97);
    chk("b50_xfers", xs.size(), 1);
    if (xs.size() == 1) begin
      chk("b50_x", xs[0], 2);
      chk("b50_y", ys[0], 4);
    end
    chk("b50_lit", lit_count, 1);

    // start presented during the DONE cycle is dropped
    frame = '1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("done_start_busy", busy, 0);
    @(negedge CLK);
    chk("done_start_busy2", busy, 0);
    chk("done_start_lit", lit_count, 1);

    // park in EMIT at (5,2), then reset without a clock edge
    frame = 96'd1 << 29;
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    chk("emit_valid", out_valid, 1);
    chk("emit_x", out_x, 5);
    chk("emit_y", out_y, 2);
    repeat (3) @(negedge CLK);
    chk("emit_hold_valid", out_valid, 1);
    chk("emit_hold_x", out_x, 5);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge CLK);
    RST = 1'b0;
    out_ready = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("arst_quiet", bad, 0);

    do_scan('0, 1'b0, 1'b0, cyc);
    chk("post_rst_latency", cyc, 96);
    chk("post_rst_xfers", xs.size(), 0);
    chk("post_rst_lit", lit_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/led_frame_scanner.md
Name: led_frame_scanner

Overview:
- Reverse direction of the snake-to-LED printer: takes a 96-bit LED frame (12 columns x 8 rows, index = x + 12*y) and emits the (x,y) coordinate of every lit LED, in ascending index order.
- Output uses a valid/ready handshake; one run per start pulse.
- Used to read back rendered frames (collision/self-check logic) and as a frame-to-coordinate checker in benches.

Parameters:
- COLS, 12, LED columns per row.
- ROWS, 8, LED rows.
- XW, 4, width of x coordinate (must hold COLS-1).
- YW, 3, width of y coordinate (must hold ROWS-1).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; snapshots frame when idle.
- frame  in  COLS*ROWS  LED bitmap, bit x+COLS*y.
- out_x  out  XW  column of current lit LED.
- out_y  out  YW  row of current lit LED.
- out_valid  out  1  out_x/out_y valid.
- out_ready  in  1  consumer accepts coordinate.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of scan.
- lit_count  out  7  number of coordinates emitted in last scan; held until next start.

Behaviour:
- Reset (async, immediate): state IDLE, out_valid=0, busy=0, done=0, out_x=0, out_y=0, lit_count=0, index/x/y counters=0, snapshot=0.
- Reset mid-scan aborts the scan at once; no done pulse; the next start begins a fresh scan.
- States:
  - IDLE: start=1 latches frame into snapshot, clears idx/x/y/count, busy=1, goes to SCAN. Otherwise stays.
  - SCAN: examines snapshot[idx]. If 1, goes to EMIT, out_x=x, out_y=y, out_valid=1 next cycle. If 0 and idx==COLS*ROWS-1, goes to DONE. If 0 otherwise, advances.
  - EMIT: out_valid=1, out_x/out_y stable. On out_ready=1: count+1, out_valid=0; goes to DONE if idx==last, otherwise advances and returns to SCAN. On out_ready=0: holds.
  - DONE: done=1 for exactly one cycle, lit_count=count, busy=0, goes to IDLE.
- Advance: idx+1, x+1. When x==COLS-1, x wraps to 0 and y increments. No divide or modulo in RTL.
- Timing:
  - Each zero bit costs 1 cycle. Each lit bit costs 1 SCAN cycle plus at least 1 EMIT cycle.
  - With start sampled at edge k and an empty frame, done is high in cycle k+97.
- start while busy is ignored. frame changes after the snapshot have no effect on the running scan.
- start in the DONE cycle is ignored; start is accepted from IDLE only.
- out_valid never deasserts without out_ready. out_x/out_y do not change while out_valid=1.
- count range is 0..96 and fits in 7 bits; no overflow possible.

Decomposition:
- Shared package holds:
  - COLS=12, ROWS=8, NLEDS=96, XW, YW.
  - The state enum (IDLE, SCAN, EMIT, DONE).
  - The index-from-xy constant function x+COLS*y, shared with the printer.
- One sub-module is natural: led_xy_counter, holding idx/x/y with clear and advance inputs, a last flag, and column wrap.

Test Plan:
- Empty frame (all 0), start pulse -> no out_valid ever, done 97 cycles after start edge, lit_count=0.
- Only bit 39 set, out_ready=1 -> exactly one transfer, out_x=3, out_y=3; then done, lit_count=1.
- Bits 0, 11, 12, 95 set, out_ready=1 -> transfers in order (0,0), (11,0), (0,1), (11,7); lit_count=4.
- All 96 bits set, out_ready toggling 1/0 every cycle -> 96 transfers row-major, coordinates stable while stalled, lit_count=96.
- Bit 50 set; change frame to 0 and pulse start during the scan -> still emits (2,4), second start ignored, lit_count=1.
- RST asserted while EMIT holds (5,2) -> out_valid/busy drop without a clock edge, no done; a new start on an empty frame gives lit_count=0.
